// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I constants and the fetch-queue entry type
package rv32i_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RV32I_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: synchronous FIFO with flush, full/empty flags and occupancy
// Ports: clk, reset (sync, active-high), flush clears contents, push/din write,
// pop/dout read the head, full/empty flags, count = occupancy.
module ifq_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full    = cnt_q == CW'(DEPTH);
  assign empty   = cnt_q == '0;
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_pop  = pop && !empty;
  // a push into a full FIFO is accepted only when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign rd_d    = flush ? '0 : rd_q + AW'(do_pop);
  assign wr_d    = flush ? '0 : wr_q + AW'(do_push);
  assign cnt_d   = flush ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk)
    if (do_push && !flush) mem_q[wr_q] <= din;
  always_ff @(posedge clk)
    if (!reset) assert (flush || !(push && full && !pop));
endmodule

// File: rtl/rv32i_ifetch_queue.sv
// rv32i_ifetch_queue: sequential instruction fetch with latency-tolerant response queue
// Ports: clk, reset (sync, active-high); redirect/redirect_pc restart fetch;
// imem_req_valid/imem_req_ready/imem_addr issue requests; imem_rsp_valid/imem_rsp_data
// return in-order responses; if_valid/if_ready/if_inst/if_pc hand instructions to the core.
module rv32i_ifetch_queue import rv32i_pkg::*; #(
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_inst,
  output logic [XLEN-1:0] if_pc
);
  localparam int CW = $clog2(DEPTH+1);
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, tag_pc;
  logic [CW-1:0] live_q, live_d, drop_q, drop_d, occ, tag_cnt;
  logic accept, data_push, data_pop, data_empty, data_full, tag_empty, tag_full;
  fetch_entry_t head, push_entry;
  // credits: live responses need FIFO room, and the tag queue bounds all outstanding requests
  assign imem_req_valid = !reset && !redirect
                          && ((CW+1)'(live_q) + (CW+1)'(occ) < (CW+1)'(DEPTH))
                          && ((CW+1)'(live_q) + (CW+1)'(drop_q) < (CW+1)'(DEPTH));
  assign imem_addr  = fetch_pc_q & ~32'd3;
  assign accept     = imem_req_valid && imem_req_ready;
  assign data_push  = imem_rsp_valid && drop_q == '0 && !redirect;
  assign if_valid   = !reset && !data_empty && !redirect;
  assign data_pop   = if_valid && if_ready;
  assign if_inst    = data_empty ? RV32I_NOP : head.inst;
  assign if_pc      = data_empty ? '0 : head.pc;
  assign push_entry = '{pc: tag_pc, inst: imem_rsp_data};
  assign fetch_pc_d = redirect ? (redirect_pc & ~32'd3) : fetch_pc_q + (accept ? 32'd4 : 32'd0);
  assign live_d     = redirect ? '0 : live_q + CW'(accept) - CW'(data_push);
  // on redirect every live response becomes owed-for-dropping, less one that lands this cycle
  assign drop_d     = redirect ? drop_q + live_q - CW'(imem_rsp_valid)
                               : drop_q - CW'(imem_rsp_valid && drop_q != '0);
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      live_q     <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      live_q     <= live_d;
      drop_q     <= drop_d;
    end
  end
  ifq_fifo #(.W($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_data (
    .clk(clk), .reset(reset), .flush(redirect), .push(data_push), .din(push_entry),
    .pop(data_pop), .dout(head), .full(data_full), .empty(data_empty), .count(occ)
  );
  // every queued tag belongs to an accepted request still owed a response, so a
  // redirect never clears this queue; stale tags are popped as their responses drop
  ifq_fifo #(.W(XLEN), .DEPTH(DEPTH)) u_tag (
    .clk(clk), .reset(reset), .flush(1'b0), .push(accept), .din(imem_addr),
    .pop(imem_rsp_valid), .dout(tag_pc), .full(tag_full), .empty(tag_empty), .count(tag_cnt)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (tag_cnt == live_q + drop_q);
      assert (!(imem_rsp_valid && tag_empty));
      assert (!(accept && tag_full));
      assert (!(data_push && data_full && !data_pop));
    end
  end
endmodule

// File: tb/tb_rv32i_ifetch_queue.sv
// tb_rv32i_ifetch_queue: directed checks of fetch, backpressure, redirect, stall and wrap
module tb_rv32i_ifetch_queue;
  localparam logic [31:0] K   = 32'h1357_9BDF;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 0, reset = 1, redirect = 0, imem_req_ready = 1, imem_rsp_valid = 0, if_ready = 1;
  logic [31:0] redirect_pc = 0, imem_rsp_data = 0;
  logic imem_req_valid, if_valid;
  logic [31:0] imem_addr, if_inst, if_pc;
  typedef struct {logic [31:0] addr; int due;} pend_t;
  pend_t pend[$];
  int cyc = 0, lat = 1, nvec = 0, nerr = 0, npop = 0, nacc = 0, p0;
  logic s_req, s_ifv, s_acc;
  logic [31:0] s_addr, s_pc, s_inst, exp_pc = 0;

  rv32i_ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one cycle: sample at negedge, score pops, then model the memory after the edge
  task automatic tick();
    @(negedge clk);
    s_req = imem_req_valid; s_addr = imem_addr; s_ifv = if_valid;
    s_pc = if_pc; s_inst = if_inst; s_acc = imem_req_valid && imem_req_ready;
    if (s_acc) nacc++;
    if (s_ifv && if_ready) begin
      chk("pop_pc", s_pc, exp_pc);
      chk("pop_inst", s_inst, exp_pc ^ K);
      exp_pc += 32'd4;
      npop++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (reset) pend.delete();
    else if (s_acc) pend.push_back('{s_addr, cyc - 1 + lat});
    imem_rsp_valid = 0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1;
      imem_rsp_data = pend[0].addr ^ K;
      void'(pend.pop_front());
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1; redirect = 0;
    repeat (n) tick();
    reset = 0; cyc = 0; exp_pc = 0;
  endtask

  initial begin
    // reset then stream, latency 1
    lat = 1; if_ready = 1; imem_req_ready = 1;
    reset = 1;
    repeat (3) tick();
    chk("rst_req_valid", 32'(s_req), 0);
    chk("rst_if_valid", 32'(s_ifv), 0);
    chk("rst_addr", s_addr, 0);
    chk("rst_inst", s_inst, NOP);
    chk("rst_pc", s_pc, 0);
    reset = 0; cyc = 0; exp_pc = 0;
    tick();
    chk("c0_req", 32'(s_req), 1);
    chk("c0_addr", s_addr, 0);
    chk("c0_ifv", 32'(s_ifv), 0);
    tick();
    chk("c1_addr", s_addr, 32'h4);
    chk("c1_ifv", 32'(s_ifv), 0);
    tick();
    chk("c2_ifv", 32'(s_ifv), 1);
    chk("c2_pc", s_pc, 0);
    repeat (6) tick();
    chk("stream_pops", npop, 7);
    chk("c8_addr", s_addr, 32'h20);

    // backpressure from reset
    if_ready = 0;
    do_reset(2);
    nacc = 0; p0 = npop;
    repeat (10) tick();
    chk("bp_accepts", nacc, 4);
    chk("bp_req_low", 32'(s_req), 0);
    chk("bp_no_pop", npop - p0, 0);
    if_ready = 1; p0 = npop;
    tick();
    chk("bp_full_req", 32'(s_req), 0);
    tick();
    chk("bp_resume_req", 32'(s_req), 1);
    chk("bp_resume_addr", s_addr, 32'h10);
    repeat (6) tick();
    chk("bp_pops", npop - p0, 8);

    // redirect with two responses in flight, latency 3
    lat = 3;
    do_reset(2);
    tick();
    tick();
    redirect = 1; redirect_pc = 32'h100; exp_pc = 32'h100;
    tick();
    chk("rd_req_low", 32'(s_req), 0);
    redirect = 0;
    tick();
    chk("rd_req", 32'(s_req), 1);
    chk("rd_addr", s_addr, 32'h100);
    tick();
    chk("rd_addr2", s_addr, 32'h104);
    tick();
    chk("rd_c5_ifv", 32'(s_ifv), 0);
    tick();
    chk("rd_c6_ifv", 32'(s_ifv), 0);
    tick();
    chk("rd_c7_ifv", 32'(s_ifv), 1);
    chk("rd_c7_pc", s_pc, 32'h100);
    repeat (8) tick();

    // redirect coincident with a response and a ready core, latency 1
    lat = 1;
    do_reset(2);
    repeat (4) tick();
    redirect = 1; redirect_pc = 32'h200; exp_pc = 32'h200; p0 = npop;
    tick();
    chk("co_ifv", 32'(s_ifv), 0);
    chk("co_nopop", npop - p0, 0);
    redirect = 0;
    tick();
    chk("co_addr", s_addr, 32'h200);
    chk("co_c5_ifv", 32'(s_ifv), 0);
    tick();
    chk("co_c6_ifv", 32'(s_ifv), 0);
    tick();
    chk("co_c7_ifv", 32'(s_ifv), 1);
    chk("co_c7_pc", s_pc, 32'h200);
    repeat (4) tick();

    // memory stall, then redirect during the stall
    imem_req_ready = 0;
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("st_req", 32'(s_req), 1);
      chk("st_addr", s_addr, 0);
    end
    redirect = 1; redirect_pc = 32'h300; exp_pc = 32'h300;
    tick();
    chk("st_rd_req", 32'(s_req), 0);
    redirect = 0; imem_req_ready = 1;
    tick();
    chk("st_new_req", 32'(s_req), 1);
    chk("st_new_addr", s_addr, 32'h300);
    tick();
    tick();
    chk("st_ifv", 32'(s_ifv), 1);
    chk("st_pc", s_pc, 32'h300);
    repeat (3) tick();

    // misaligned redirect near the top of the address space
    do_reset(2);
    tick();
    redirect = 1; redirect_pc = 32'hFFFF_FFFE; exp_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 0;
    tick();
    chk("wr_addr0", s_addr, 32'hFFFF_FFFC);
    tick();
    chk("wr_addr1", s_addr, 32'h0);
    tick();
    chk("wr_ifv", 32'(s_ifv), 1);
    chk("wr_pc0", s_pc, 32'hFFFF_FFFC);
    tick();
    chk("wr_pc1", s_pc, 32'h0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
